y86_fetch_stage: RTL
====================

Y86_FETCH_STAGE -- requirements
Module: y86_fetch_stage

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the instruction-memory size in bytes.
REQ-002 SHALL have parameter AW, default 10, giving the imem address width (2^AW = MEM_BYTES).
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on the posedge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 F_stall  in  1  holds the fetch PC register.
REQ-007 M_Ins_Code  in  4  icode in Memory stage.
REQ-008 M_Cnd  in  1  branch condition in Memory stage.
REQ-009 M_Val_A  in  64  fall-through PC of a mispredicted jXX.
REQ-010 W_Ins_Code  in  4  icode in Writeback stage.
REQ-011 W_Val_M  in  64  return address popped by ret.
REQ-012 imem_we  in  1  instruction-memory byte write enable.
REQ-013 imem_addr  in  AW  byte address for the write.
REQ-014 imem_wdata  in  8  byte to write.
REQ-015 f_stat, f_Ins_Code, f_Ins_fun, f_rA, f_rB  out  3/4/4/4/4  decoded fields.
REQ-016 f_Val_C  out  64 signed  and  f_Val_P  out  64  constant and next sequential PC.
REQ-017 f_PC  out  64  selected PC; F_predPC  out  64  predicted-PC register.

Function
REQ-018 Status codes SHALL be AOK=0, HLT=1, ADR=2, INS=3.
REQ-019 f_PC SHALL be selected combinationally: M_Val_A if M_Ins_Code=7 and M_Cnd=0; else W_Val_M if W_Ins_Code=9; else F_predPC. Mispredict wins when both conditions hold.
REQ-020 Byte 0 at f_PC SHALL split into icode (high nibble) and ifun (low nibble).
REQ-021 Lengths SHALL be: 1 for icode 0, 1 and 9; 2 for icode 2, 6, A and B; 9 for icode 7 and 8; 10 for icode 3, 4 and 5.
REQ-022 For icodes with a register byte, byte 1 SHALL give rA (high nibble) and rB (low nibble); otherwise both SHALL be 4'hF.
REQ-023 f_Val_C SHALL be the 8 little-endian bytes starting at byte 2 for icode 3/4/5, at byte 1 for icode 7/8, and 0 otherwise.
REQ-024 f_Val_P SHALL equal f_PC + length, modulo 2^64.
REQ-025 Valid ifun SHALL be 0..3 for icode 6 and 0..6 for icode 2/7; every other icode SHALL require ifun=0. Icode above B, or an invalid ifun, SHALL set f_stat=INS.
REQ-026 If f_PC >= MEM_BYTES, or f_PC + length - 1 >= MEM_BYTES, then: f_stat=ADR, f_Ins_Code=1, f_Ins_fun=0, f_rA=f_rB=F, f_Val_C=0. ADR SHALL take priority over INS and HLT.
REQ-027 icode 0 with no error SHALL give f_stat=HLT; otherwise f_stat SHALL be AOK.
REQ-028 The predicted PC SHALL be f_Val_C for icode 7 or 8 and f_Val_P otherwise. F_predPC SHALL load it at each posedge when rst=0 and F_stall=0, and hold when F_stall=1.
REQ-029 All f_* outputs SHALL be combinational from F_predPC, the M/W inputs and memory: zero-cycle latency, captured by the decode register on the next posedge.
REQ-030 An imem write SHALL take effect at the posedge. A same-cycle fetch of the written address SHALL see the old byte.
REQ-031 imem writes SHALL be honoured during reset and during stall.

Reset
REQ-032 With rst=1 at a posedge, F_predPC SHALL become 0, overriding F_stall and the prediction.
REQ-033 Reset SHALL NOT clear instruction memory.
REQ-034 After reset, with no M/W redirect, f_PC SHALL be 0 and the f_* outputs SHALL decode address 0.

Verification
REQ-035 Load 30 F3 08 00 00 00 00 00 00 00 at 0, then reset -> f_Ins_Code=3, f_rA=F, f_rB=3, f_Val_C=8, f_Val_P=10, next F_predPC=10.
REQ-036 jXX 70 00 01 00 00 00 00 00 00 at 0 -> f_Val_P=9, F_predPC=0x100. Then M_Ins_Code=7, M_Cnd=0, M_Val_A=9 -> f_PC=9 in that cycle.
REQ-037 Both a mispredict (M_Val_A=0x20) and W ret (W_Val_M=0x40) in the same cycle -> f_PC=0x20.
REQ-038 F_stall=1 for 3 cycles -> F_predPC and all f_* constant. rst=1 during stall -> F_predPC=0 at the next posedge.
REQ-039 irmovq at address MEM_BYTES-5 -> f_stat=2, f_Ins_Code=1. Byte 0xC0 -> f_stat=3. Byte 0x00 -> f_stat=1. Byte 0x64 -> f_stat=3.
REQ-040 ret (90) at 0x10, then W_Ins_Code=9 with W_Val_M=0x30 -> f_PC=0x30 and F_predPC=0x30+length at the next posedge.

Source files
------------

// File: rtl/y86_fetch_stage.sv
// Y86-64 pipeline fetch stage: PC selection, byte-addressed instruction memory,
// instruction split/length/status decode and the predicted-PC register.
module y86_fetch_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               F_stall,
  input  logic [3:0]         M_Ins_Code,
  input  logic               M_Cnd,
  input  logic [63:0]        M_Val_A,
  input  logic [3:0]         W_Ins_Code,
  input  logic [63:0]        W_Val_M,
  input  logic               imem_we,
  input  logic [AW-1:0]      imem_addr,
  input  logic [7:0]         imem_wdata,
  output logic [2:0]         f_stat,
  output logic [3:0]         f_Ins_Code,
  output logic [3:0]         f_Ins_fun,
  output logic [3:0]         f_rA,
  output logic [3:0]         f_rB,
  output logic signed [63:0] f_Val_C,
  output logic [63:0]        f_Val_P,
  output logic [63:0]        f_PC,
  output logic [63:0]        F_predPC
);

  localparam logic [2:0]  STAT_AOK  = 3'd0;
  localparam logic [2:0]  STAT_HLT  = 3'd1;
  localparam logic [2:0]  STAT_ADR  = 3'd2;
  localparam logic [2:0]  STAT_INS  = 3'd3;
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  logic [7:0]  imem [MEM_BYTES];
  logic [7:0]  ibyte [10];
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  raw_len;
  logic [3:0]  eff_len;
  logic [3:0]  max_fun;
  logic        has_regs;
  logic        adr_err;
  logic        ins_err;
  logic [63:0] val_c_raw;
  logic [63:0] pred_pc;

  // Byte write port; reads below are asynchronous so a same-cycle fetch sees the old byte.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  // A mispredicted jXX outranks a returning ret.
  always_comb begin
    if ((M_Ins_Code == 4'h7) && !M_Cnd) begin
      f_PC = M_Val_A;
    end else if (W_Ins_Code == 4'h9) begin
      f_PC = W_Val_M;
    end else begin
      f_PC = F_predPC;
    end
  end

  for (genvar k = 0; k < 10; k++) begin : g_bytes
    assign ibyte[k] = imem[f_PC[AW-1:0] + AW'(k)];
  end

  assign icode = ibyte[0][7:4];
  assign ifun  = ibyte[0][3:0];

  // Per-icode length, register-byte presence and highest legal ifun.
  always_comb begin
    raw_len  = 4'd1;
    has_regs = 1'b0;
    max_fun  = 4'd0;
    case (icode)
      4'h0, 4'h1, 4'h9: raw_len = 4'd1;
      4'h2: begin raw_len = 4'd2; has_regs = 1'b1; max_fun = 4'd6; end
      4'h6: begin raw_len = 4'd2; has_regs = 1'b1; max_fun = 4'd3; end
      4'hA, 4'hB: begin raw_len = 4'd2; has_regs = 1'b1; end
      4'h7: begin raw_len = 4'd9; max_fun = 4'd6; end
      4'h8: raw_len = 4'd9;
      4'h3, 4'h4, 4'h5: begin raw_len = 4'd10; has_regs = 1'b1; end
      default: raw_len = 4'd1;
    endcase
  end

  // Little-endian constant word.
  always_comb begin
    case (icode)
      4'h3, 4'h4, 4'h5: val_c_raw = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                                     ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
      4'h7, 4'h8:       val_c_raw = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                                     ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
      default:          val_c_raw = 64'd0;
    endcase
  end

  // The end-address test cannot overflow: it only matters once f_PC is below MEM_LIMIT.
  assign adr_err = (f_PC >= MEM_LIMIT) ||
                   ((f_PC + 64'(raw_len) - 64'd1) >= MEM_LIMIT);
  assign ins_err = (icode > 4'hB) || (ifun > max_fun);

  // An address fault presents as a one-byte nop so the next PC stays well defined.
  always_comb begin
    if (adr_err) begin
      f_stat     = STAT_ADR;
      f_Ins_Code = 4'h1;
      f_Ins_fun  = 4'h0;
      f_rA       = 4'hF;
      f_rB       = 4'hF;
      f_Val_C    = 64'sd0;
      eff_len    = 4'd1;
    end else begin
      if (ins_err) begin
        f_stat = STAT_INS;
      end else if (icode == 4'h0) begin
        f_stat = STAT_HLT;
      end else begin
        f_stat = STAT_AOK;
      end
      f_Ins_Code = icode;
      f_Ins_fun  = ifun;
      f_rA       = has_regs ? ibyte[1][7:4] : 4'hF;
      f_rB       = has_regs ? ibyte[1][3:0] : 4'hF;
      f_Val_C    = $signed(val_c_raw);
      eff_len    = raw_len;
    end
  end

  assign f_Val_P = f_PC + 64'(eff_len);
  assign pred_pc = ((f_Ins_Code == 4'h7) || (f_Ins_Code == 4'h8)) ? $unsigned(f_Val_C) : f_Val_P;

  // Predicted-PC register: reset beats stall, stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_predPC <= 64'd0;
    end else if (!F_stall) begin
      F_predPC <= pred_pc;
    end
  end

endmodule
